// File: rtl/sipo_deserializer_pkg.sv
// Shared constants for the serial shift blocks: extension-type encodings.
package sipo_deserializer_pkg;

    // Fill used for the vacated MSBs of a flushed partial word.
    localparam logic EXT_LOGIC = 1'b0;
    localparam logic EXT_ARITH = 1'b1;

    // Fill bit for a partial word: zero, or a copy of the newest (most significant) bit.
    function automatic logic fill_bit(input logic ext_type, input logic msb);
        return (ext_type == EXT_ARITH) ? msb : 1'b0;
    endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial input, parallel output and status bundle of the deserializer.
interface sipo_deserializer_if #(
    parameter int unsigned w = 4
);
    logic                   s_in;
    logic                   s_en;
    logic                   flush;
    logic                   ext_type;
    logic [w-1:0]           dout;
    logic                   dout_valid;
    logic                   dout_ready;
    logic [$clog2(w)-1:0]   bit_cnt;
    logic                   overrun;

    // Serial link and consumer side.
    modport master (
        output s_in, s_en, flush, ext_type, dout_ready,
        input  dout, dout_valid, bit_cnt, overrun
    );

    // Deserializer side.
    modport slave (
        input  s_in, s_en, flush, ext_type, dout_ready,
        output dout, dout_valid, bit_cnt, overrun
    );
endinterface

// File: rtl/sipo_deserializer_align_ext.sv
// Right-aligns the k newest bits of the shift register and extends the vacated MSBs.
module sipo_deserializer_align_ext
    import sipo_deserializer_pkg::*;
#(
    parameter int unsigned w  = 4,
    parameter int unsigned KW = $clog2(w + 1)
) (
    input  logic [w-1:0]  sr_n_i,
    input  logic [KW-1:0] k_i,
    input  logic          ext_type_i,
    output logic [w-1:0]  word_o
);

    logic fill;

    assign fill = fill_bit(ext_type_i, sr_n_i[w-1]);

    // The k received bits sit in the top of sr_n; bit i of the word comes from i + (w - k).
    always_comb begin
        word_o = '0;
        for (int i = 0; i < int'(w); i++) begin
            if (i < int'(k_i)) begin
                word_o[i] = sr_n_i[i + int'(w) - int'(k_i)];
            end else begin
                word_o[i] = fill;
            end
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out receiver: LSB-first bits assembled into w-bit words,
// double-buffered behind a valid/ready output register.
module sipo_deserializer
    import sipo_deserializer_pkg::*;
#(
    parameter int unsigned  w       = 4,
    parameter logic [w-1:0] rst_val = '0
) (
    input logic               clk,
    input logic               rst,
    sipo_deserializer_if.slave bus_io
);

    localparam int unsigned CntW = $clog2(w);
    localparam int unsigned KW   = $clog2(w + 1);

    logic [w-1:0]    sr_q, sr_n;
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    logic [KW-1:0]   k;
    logic [w-1:0]    dout_q, dout_d;
    logic            valid_q, valid_d;
    logic            overrun_q, overrun_d;
    logic [w-1:0]    word;
    logic            complete;
    logic            accept;

    // Bit intake: shift the new bit in at the top and count it.
    always_comb begin
        sr_n = bus_io.s_en ? {bus_io.s_in, sr_q[w-1:1]} : sr_q;
        k    = KW'(bit_cnt_q) + KW'(bus_io.s_en);
    end

    sipo_deserializer_align_ext #(
        .w  (w),
        .KW (KW)
    ) u_align_ext (
        .sr_n_i     (sr_n),
        .k_i        (k),
        .ext_type_i (bus_io.ext_type),
        .word_o     (word)
    );

    // Completion and output handshake; a word that finds the holding register busy is dropped.
    always_comb begin
        complete  = (k == KW'(w)) || (bus_io.flush && (k != '0));
        accept    = valid_q && bus_io.dout_ready;
        bit_cnt_d = complete ? '0 : CntW'(k);
        dout_d    = dout_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (complete && (!valid_q || accept)) begin
            dout_d  = word;
            valid_d = 1'b1;
        end else begin
            if (complete) begin
                overrun_d = 1'b1;
            end
            if (accept) begin
                valid_d = 1'b0;
            end
        end
    end

    // State registers; reset discards any partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
            dout_q    <= rst_val;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sr_q      <= sr_n;
            bit_cnt_q <= bit_cnt_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus_io.dout       = dout_q;
    assign bus_io.dout_valid = valid_q;
    assign bus_io.bit_cnt    = bit_cnt_q;
    assign bus_io.overrun    = overrun_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: directed scenarios plus random traffic on a w=4 and a w=8
// instance, both checked against a bit-list reference model.
module tb_sipo_deserializer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sipo_deserializer_if #(.w(4)) b4 ();
    sipo_deserializer_if #(.w(8)) b8 ();

    sipo_deserializer #(.w(4), .rst_val(4'h0)) dut4 (.clk(clk), .rst(rst), .bus_io(b4));
    sipo_deserializer #(.w(8), .rst_val(8'hA5)) dut8 (.clk(clk), .rst(rst), .bus_io(b8));

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state, index 0 = w4 instance, 1 = w8 instance.
    int         m_w   [2] = '{4, 8};
    logic [7:0] m_rst [2] = '{8'h00, 8'hA5};
    bit         m_bits[2][8];
    int         m_n   [2];
    logic [7:0] m_dout[2];
    bit         m_valid[2];
    bit         m_ovr [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_n[i]     = 0;
            m_dout[i]  = m_rst[i];
            m_valid[i] = 1'b0;
            m_ovr[i]   = 1'b0;
        end
    endtask

    // One clock edge of the receiver: bits are kept as a list, first bit = word LSB.
    task automatic model_step(input int i, input bit en, input bit d, input bit fl,
                              input bit ext, input bit rdy);
        bit         done;
        bit         acc;
        logic [7:0] wrd;
        if (en) begin
            m_bits[i][m_n[i]] = d;
            m_n[i]++;
        end
        done     = (m_n[i] == m_w[i]) || (fl && m_n[i] > 0);
        acc      = m_valid[i] && rdy;
        m_ovr[i] = 1'b0;
        if (done) begin
            wrd = '0;
            for (int j = 0; j < m_n[i]; j++) wrd[j] = m_bits[i][j];
            if (ext && m_bits[i][m_n[i]-1]) begin
                for (int j = m_n[i]; j < m_w[i]; j++) wrd[j] = 1'b1;
            end
            m_n[i] = 0;
            if (!m_valid[i] || acc) begin
                m_dout[i]  = wrd;
                m_valid[i] = 1'b1;
            end else begin
                m_ovr[i] = 1'b1;
            end
        end else if (acc) begin
            m_valid[i] = 1'b0;
        end
    endtask

    task automatic check_all();
        check_eq("w4_dout",    b4.dout,       m_dout[0][3:0]);
        check_eq("w4_valid",   b4.dout_valid, m_valid[0]);
        check_eq("w4_bit_cnt", b4.bit_cnt,    m_n[0]);
        check_eq("w4_overrun", b4.overrun,    m_ovr[0]);
        check_eq("w8_dout",    b8.dout,       m_dout[1]);
        check_eq("w8_valid",   b8.dout_valid, m_valid[1]);
        check_eq("w8_bit_cnt", b8.bit_cnt,    m_n[1]);
        check_eq("w8_overrun", b8.overrun,    m_ovr[1]);
    endtask

    task automatic drive4(input bit en, input bit d, input bit fl, input bit ext, input bit rdy);
        b4.s_en = en; b4.s_in = d; b4.flush = fl; b4.ext_type = ext; b4.dout_ready = rdy;
    endtask

    task automatic drive8(input bit en, input bit d, input bit fl, input bit ext, input bit rdy);
        b8.s_en = en; b8.s_in = d; b8.flush = fl; b8.ext_type = ext; b8.dout_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, b4.s_en, b4.s_in, b4.flush, b4.ext_type, b4.dout_ready);
        model_step(1, b8.s_en, b8.s_in, b8.flush, b8.ext_type, b8.dout_ready);
        #1;
        check_all();
    endtask

    // Strobe a list of bits into the w4 instance, first element first.
    task automatic send4(input logic [3:0] bits, input int n, input bit rdy);
        for (int j = 0; j < n; j++) begin
            drive4(1'b1, bits[j], 1'b0, 1'b0, rdy);
            tick();
        end
        drive4(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send8(input logic [7:0] bits, input int n);
        for (int j = 0; j < n; j++) begin
            drive8(1'b1, bits[j], 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive8(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        drive4(0, 0, 0, 0, 0);
        drive8(0, 0, 0, 0, 0);
        rst = 1'b1;
        #12;
        model_reset();
        check_all();
        check_eq("w8_rst_val", b8.dout, 8'hA5);
        @(negedge clk);
        rst = 1'b0;

        // Full word 1,1,1,0 held, then accepted.
        send4(4'b0111, 4, 1'b0);
        check_eq("t1_dout", b4.dout, 4'b0111);
        check_eq("t1_valid", b4.dout_valid, 1'b1);
        drive4(0, 0, 0, 0, 1); tick();
        check_eq("t1_acc_valid", b4.dout_valid, 1'b0);
        check_eq("t1_acc_dout", b4.dout, 4'b0111);

        // Partial words 0,0,1 flushed with zero then sign extension.
        send4(4'b0100, 3, 1'b0);
        drive4(0, 0, 1, 0, 0); tick();
        check_eq("t2_zext", b4.dout, 4'b0100);
        drive4(0, 0, 0, 0, 1); tick();
        send4(4'b0100, 3, 1'b0);
        drive4(0, 0, 1, 1, 0); tick();
        check_eq("t2_sext", b4.dout, 4'b1100);
        drive4(0, 0, 0, 0, 1); tick();
        drive4(0, 0, 1, 1, 0); tick();
        check_eq("t2_empty_flush", b4.dout_valid, 1'b0);

        // Overrun: 0101 held, 0011 completes and is dropped.
        send4(4'b0101, 4, 1'b0);
        send4(4'b0011, 4, 1'b0);
        check_eq("t3_overrun", b4.overrun, 1'b1);
        check_eq("t3_dout", b4.dout, 4'b0101);
        tick();
        check_eq("t3_ovr_pulse", b4.overrun, 1'b0);

        // Completion coinciding with accept keeps valid high.
        send4(4'b0110, 3, 1'b0);
        check_eq("t4_valid_hold", b4.dout_valid, 1'b1);
        drive4(1, 0, 0, 0, 1); tick();
        check_eq("t4_dout", b4.dout, 4'b0110);
        check_eq("t4_valid", b4.dout_valid, 1'b1);
        check_eq("t4_overrun", b4.overrun, 1'b0);
        drive4(0, 0, 0, 0, 1); tick();
        drive4(0, 0, 0, 0, 0);

        // Asynchronous reset mid-cycle drops a partial word at once.
        send4(4'b0011, 2, 1'b0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_eq("t5_cnt", b4.bit_cnt, 0);
        check_eq("t5_dout", b4.dout, 4'h0);
        check_eq("t5_valid", b4.dout_valid, 1'b0);
        check_eq("t5_w8_dout", b8.dout, 8'hA5);
        #1 rst = 1'b0;
        send4(4'b1001, 4, 1'b0);
        check_eq("t5_word", b4.dout, 4'b1001);

        // w=8: full byte, then five bits sign-extended.
        send8(8'h3C, 8);
        check_eq("t6_3c", b8.dout, 8'h3C);
        drive8(0, 0, 0, 0, 1); tick();
        send8(8'h1D, 5);
        drive8(0, 0, 1, 1, 0); tick();
        check_eq("t6_fd", b8.dout, 8'hFD);
        drive8(0, 0, 0, 0, 1); tick();

        // Random traffic on both instances.
        for (int c = 0; c < 600; c++) begin
            drive4($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 9) == 0,
                   1'($urandom), $urandom_range(0, 2) != 0);
            drive8($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 14) == 0,
                   1'($urandom), $urandom_range(0, 3) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
